// File: rtl/music_game_pkg.sv
// Shared types for the note game: column geometry, spawner FSM states and the
// spawn event record carried through the spawn queue.
package music_game_pkg;

   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned COL_W    = 2;
   localparam int unsigned ID_W     = 8;
   localparam int unsigned EVT_W    = COL_W + ID_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } spawn_state_e;

   typedef struct packed {
      logic [COL_W-1:0] col;
      logic [ID_W-1:0]  id;
   } spawn_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/random_note_spawner.sv
// Turns beat ticks into queued note-spawn events in random mode, limiting
// consecutive repeats of the same column and tagging each event with an id.
module random_note_spawner
   import music_game_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_REPEAT = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               clear,
   input  logic                               beat_tick,
   input  logic [3:0]                         random_col,
   input  logic                               spawn_ready,
   output logic                               spawn_valid,
   output logic [COL_W-1:0]                   spawn_col,
   output logic [ID_W-1:0]                    spawn_id,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               overflow,
   output logic                               busy
);

   localparam int unsigned RUN_W = $clog2(MAX_REPEAT + 1);

   spawn_state_e      state_q, state_d;
   logic [ID_W-1:0]   next_id_q, next_id_d;
   logic              hist_valid_q, hist_valid_d;
   logic [COL_W-1:0]  last_col_q, last_col_d;
   logic [RUN_W-1:0]  run_len_q, run_len_d;
   logic              overflow_q, overflow_d;

   logic              fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH+1)-1:0] count;
   spawn_evt_t        push_evt, head_evt;
   logic              tick_req, push_acc, pop_acc, repeat_hit;
   logic [COL_W-1:0]  raw_col, sel_col;
   logic [RUN_W-1:0]  sel_run;
   logic              unused_col_hi;

   assign raw_col       = random_col[COL_W-1:0];
   assign unused_col_hi = ^random_col[3:2];

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (clear),
      .push_i  (push_acc),
      .pop_i   (pop_acc),
      .wdata_i (push_evt),
      .rdata_o (head_evt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         next_id_q    <= '0;
         hist_valid_q <= 1'b0;
         last_col_q   <= '0;
         run_len_q    <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         next_id_q    <= next_id_d;
         hist_valid_q <= hist_valid_d;
         last_col_q   <= last_col_d;
         run_len_q    <= run_len_d;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      next_id_d    = next_id_q;
      hist_valid_d = hist_valid_q;
      last_col_d   = last_col_q;
      run_len_d    = run_len_q;
      overflow_d   = overflow_q;
      sel_col      = raw_col;
      sel_run      = RUN_W'(1);

      pop_acc    = spawn_ready && !fifo_empty && !clear;
      tick_req   = (state_q == ST_RUN) && beat_tick && !clear;
      push_acc   = tick_req && (!fifo_full || pop_acc);
      repeat_hit = hist_valid_q && (raw_col == last_col_q);

      // A column already used MAX_REPEAT times in a row is bumped to its neighbour
      if (repeat_hit && (run_len_q == RUN_W'(MAX_REPEAT))) begin
         sel_col = COL_W'(raw_col + 1'b1);
      end else if (repeat_hit) begin
         sel_run = RUN_W'(run_len_q + 1'b1);
      end

      if (tick_req && !push_acc) overflow_d = 1'b1;
      if (push_acc) begin
         hist_valid_d = 1'b1;
         last_col_d   = sel_col;
         run_len_d    = sel_run;
         next_id_d    = ID_W'(next_id_q + 1'b1);
      end

      unique case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = fifo_empty ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: begin
            if (enable)          state_d = ST_RUN;
            else if (fifo_empty) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      if (clear) begin
         state_d      = ST_IDLE;
         next_id_d    = '0;
         hist_valid_d = 1'b0;
         last_col_d   = '0;
         run_len_d    = '0;
         overflow_d   = 1'b0;
      end
   end

   assign push_evt.col = sel_col;
   assign push_evt.id  = next_id_q;

   assign spawn_valid = !fifo_empty;
   assign spawn_col   = head_evt.col;
   assign spawn_id    = head_evt.id;
   assign fifo_count  = count;
   assign overflow    = overflow_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_random_note_spawner.sv
// Randomized and scenario bench for random_note_spawner, checked against a
// queue-based behavioural model of the spawn rules.
module tb_random_note_spawner;

   localparam int DEPTH = 8;
   localparam int MAXR  = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic       clk = 1'b0;
   logic       rst, enable, clear, beat_tick, spawn_ready;
   logic [3:0] random_col;
   logic       spawn_valid, overflow, busy;
   logic [1:0] spawn_col;
   logic [7:0] spawn_id;
   logic [3:0] fifo_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { int col; int id; } evt_t;
   evt_t q[$];
   int   hist[$];
   int   m_next_id;
   bit   m_ovf;
   int   m_mode;

   random_note_spawner #(.FIFO_DEPTH(DEPTH), .MAX_REPEAT(MAXR)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear       (clear),
      .beat_tick   (beat_tick),
      .random_col  (random_col),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .spawn_col   (spawn_col),
      .spawn_id    (spawn_id),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      hist.delete();
      m_next_id = 0;
      m_ovf     = 1'b0;
      m_mode    = M_IDLE;
   endfunction

   // Length of the run of identical columns at the end of the accepted history
   function automatic int trailing_run();
      int n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != hist[hist.size()-1]) break;
         n++;
      end
      return n;
   endfunction

   function automatic void model_step(input bit en, input bit clr, input bit tick,
                                      input int col, input bit rdy);
      bit do_pop;
      bit do_push;
      int nmode;
      int c;
      if (clr) begin
         model_reset();
         return;
      end
      do_pop  = rdy && (q.size() > 0);
      do_push = (m_mode == M_RUN) && tick;
      if (do_push && q.size() == DEPTH && !do_pop) begin
         m_ovf   = 1'b1;
         do_push = 1'b0;
      end
      nmode = m_mode;
      if (m_mode == M_IDLE && en) nmode = M_RUN;
      else if (m_mode == M_RUN && !en) nmode = (q.size() > 0) ? M_DRAIN : M_IDLE;
      else if (m_mode == M_DRAIN) begin
         if (en) nmode = M_RUN;
         else if (q.size() == 0) nmode = M_IDLE;
      end
      m_mode = nmode;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         c = col % 4;
         if (hist.size() > 0 && hist[hist.size()-1] == c && trailing_run() == MAXR)
            c = (c + 1) % 4;
         hist.push_back(c);
         if (hist.size() > 16) void'(hist.pop_front());
         q.push_back('{col: c, id: m_next_id});
         m_next_id = (m_next_id + 1) % 256;
      end
   endfunction

   task automatic compare_all();
      check("spawn_valid", 32'(spawn_valid), 32'(q.size() > 0));
      check("fifo_count",  32'(fifo_count),  32'(q.size()));
      check("overflow",    32'(overflow),    32'(m_ovf));
      check("busy",        32'(busy),        32'(m_mode != M_IDLE));
      if (q.size() > 0) begin
         check("spawn_col", 32'(spawn_col), 32'(q[0].col));
         check("spawn_id",  32'(spawn_id),  32'(q[0].id));
      end
   endtask

   task automatic step(input bit en, input bit clr, input bit tick,
                       input logic [3:0] col, input bit rdy);
      @(negedge clk);
      enable      = en;
      clear       = clr;
      beat_tick   = tick;
      random_col  = col;
      spawn_ready = rdy;
      model_step(en, clr, tick, int'(col), rdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      logic [3:0] cols6 [6];
      logic [3:0] cols9 [9];
      cols6 = '{4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0};
      cols9 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

      rst = 1'b1; enable = 1'b0; clear = 1'b0; beat_tick = 1'b0;
      random_col = 4'd0; spawn_ready = 1'b0;
      model_reset();
      #2;
      compare_all();
      check("reset_col", 32'(spawn_col), 32'd0);
      check("reset_id",  32'(spawn_id),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      // First event appears at the head one cycle after its tick
      step(1, 0, 0, 4'd0, 0);
      step(1, 0, 1, 4'd2, 0);
      check("first_id", 32'(spawn_id), 32'd0);
      check("first_col", 32'(spawn_col), 32'd2);

      // Repeat limiter with the consumer always ready
      step(1, 1, 0, 4'd0, 0);
      step(1, 0, 0, 4'd0, 1);
      for (int i = 0; i < 6; i++) step(1, 0, 1, cols6[i], 1);
      for (int i = 0; i < 2; i++) step(1, 0, 0, 4'd0, 1);

      // Overflow: nine ticks into an eight-deep queue, then pop + tick
      step(1, 1, 0, 4'd0, 0);
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 9; i++) step(1, 0, 1, cols9[i], 0);
      check("ovf_count", 32'(fifo_count), 32'd8);
      check("ovf_flag",  32'(overflow),   32'd1);
      step(1, 0, 0, 4'd0, 1);
      step(1, 0, 1, 4'd1, 0);
      // Full queue: tick and pop in the same cycle
      step(1, 0, 1, 4'd2, 1);
      check("full_pushpop_count", 32'(fifo_count), 32'd8);
      for (int i = 0; i < 9; i++) step(1, 0, 0, 4'd0, 1);

      // Drain: ticks ignored while draining, idle once empty
      step(1, 1, 0, 4'd0, 0);
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 4'(i), 0);
      step(0, 0, 0, 4'd0, 0);
      step(0, 0, 1, 4'd1, 0);
      check("drain_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 4'd2, 1);
      check("drain_empty", 32'(fifo_count), 32'd0);
      step(0, 0, 0, 4'd0, 0);
      check("drain_idle", 32'(busy), 32'd0);
      step(1, 0, 0, 4'd0, 0);
      step(1, 0, 1, 4'd3, 0);
      step(1, 1, 1, 4'd3, 1);
      step(1, 0, 0, 4'd0, 0);
      step(1, 0, 1, 4'd1, 0);
      check("post_clear_id", 32'(spawn_id), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2) != 0);
      end

      // Asynchronous reset with events queued
      step(1, 1, 0, 4'd0, 0);
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 4'($urandom_range(0, 15)), 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_valid", 32'(spawn_valid), 32'd0);
      check("arst_count", 32'(fifo_count),  32'd0);
      check("arst_ovf",   32'(overflow),    32'd0);
      check("arst_busy",  32'(busy),        32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 4'd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
